assoc_cache_ctrl: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate cache with a built-in controller FSM and true-LRU replacement. It sits between a word-granular requester and a line-granular memory port. It generalises the fixed 4-way, 128-set, 64-byte cache datapath and handles the whole sequence on its own: lookup, victim selection, dirty writeback, refill, and the final access. Hit and miss statistics counters are included.

---
 rtl/assoc_cache_ctrl_if.sv | 31 +++
 rtl/assoc_cache_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_assoc_cache_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/assoc_cache_ctrl_if.sv
// Requester and line-memory bus of assoc_cache_ctrl; the cache takes the slave view.
interface assoc_cache_ctrl_if #(
   parameter int WORD_SIZE  = 4,
   parameter int BLOCK_SIZE = 64
);
   logic                    req_valid;
   logic                    req_write;
   logic [31:0]             req_addr;
   logic [WORD_SIZE*8-1:0]  req_wdata;
   logic                    req_ready;
   logic                    resp_valid;
   logic [WORD_SIZE*8-1:0]  resp_rdata;
   logic                    resp_hit;
   logic                    mem_req;
   logic                    mem_write;
   logic [31:0]             mem_addr;
   logic [BLOCK_SIZE*8-1:0] mem_wdata;
   logic                    mem_ack;
   logic [BLOCK_SIZE*8-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_hit,
             mem_req, mem_write, mem_addr, mem_wdata
   );
   modport master (
      output req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_hit,
             mem_req, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/assoc_cache_ctrl.sv
// N-way set-associative write-back/write-allocate cache with its own controller
// FSM, true-LRU replacement and wrapping hit/miss counters.

module assoc_cache_way_cmp #(
   parameter int TAG_BITS = 19
) (
   input  logic                valid,
   input  logic [TAG_BITS-1:0] tag,
   input  logic [TAG_BITS-1:0] req_tag,
   output logic                hit
);
   assign hit = valid && (tag == req_tag);
endmodule

module assoc_cache_ctrl #(
   parameter int BLOCK_SIZE = 64,
   parameter int NO_SETS    = 128,
   parameter int CACHE_TYPE = 4,
   parameter int WORD_SIZE  = 4
) (
   input  logic               clk,
   input  logic               rst,
   assoc_cache_ctrl_if.slave  bus,
   output logic [31:0]        hit_count,
   output logic [31:0]        miss_count
);
   localparam int OFFSET_BITS = $clog2(BLOCK_SIZE);
   localparam int INDEX_BITS  = $clog2(NO_SETS);
   localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS;
   localparam int AGE_BITS    = $clog2(CACHE_TYPE);
   localparam int WB          = $clog2(WORD_SIZE);
   localparam int WSEL_BITS   = OFFSET_BITS - WB;
   localparam int WW          = WORD_SIZE * 8;
   localparam int LW          = BLOCK_SIZE * 8;

   typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;
   state_t state;

   // Data and tags are never reset; only the per-line state bits are.
   logic [LW-1:0]       data_arr [NO_SETS][CACHE_TYPE];
   logic [TAG_BITS-1:0] tag_arr  [NO_SETS][CACHE_TYPE];
   logic [NO_SETS-1:0][CACHE_TYPE-1:0]               valid_arr;
   logic [NO_SETS-1:0][CACHE_TYPE-1:0]               dirty_arr;
   logic [NO_SETS-1:0][CACHE_TYPE-1:0][AGE_BITS-1:0] age_arr;
   logic [CACHE_TYPE-1:0][AGE_BITS-1:0]              age_init;

   logic [31:0]         addr_r;
   logic [WW-1:0]       wdata_r;
   logic                write_r;
   logic                hit_r;
   logic [AGE_BITS-1:0] way_r;

   logic [TAG_BITS-1:0]  req_tag;
   logic [INDEX_BITS-1:0] idx;
   logic [WSEL_BITS-1:0] wsel;
   logic [LW-1:0]        cur_line;
   logic                 unused_addr_bits;

   assign req_tag          = addr_r[31 -: TAG_BITS];
   assign idx              = addr_r[OFFSET_BITS +: INDEX_BITS];
   assign wsel             = addr_r[OFFSET_BITS-1 -: WSEL_BITS];
   assign cur_line         = data_arr[idx][way_r];
   assign unused_addr_bits = ^addr_r[WB-1:0];

   logic [CACHE_TYPE-1:0] hit_vec;
   genvar gw;
   generate
      for (gw = 0; gw < CACHE_TYPE; gw++) begin : g_way
         assign age_init[gw] = AGE_BITS'(gw);
         assoc_cache_way_cmp #(.TAG_BITS(TAG_BITS)) u_cmp (
            .valid   (valid_arr[idx][gw]),
            .tag     (tag_arr[idx][gw]),
            .req_tag (req_tag),
            .hit     (hit_vec[gw])
         );
      end
   endgenerate

   logic                hit_any;
   logic                inv_found;
   logic [AGE_BITS-1:0] hit_way;
   logic [AGE_BITS-1:0] victim;

   // Victim: lowest-indexed invalid way, else the oldest way.
   always_comb begin
      hit_any   = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      victim    = '0;
      for (int w = CACHE_TYPE-1; w >= 0; w--) begin
         if (hit_vec[w]) begin
            hit_any = 1'b1;
            hit_way = AGE_BITS'(w);
         end
         if (!valid_arr[idx][w]) begin
            inv_found = 1'b1;
            victim    = AGE_BITS'(w);
         end
      end
      if (!inv_found)
         for (int w = 0; w < CACHE_TYPE; w++)
            if (age_arr[idx][w] == AGE_BITS'(CACHE_TYPE-1)) victim = AGE_BITS'(w);
   end

   assign bus.req_ready = (state == IDLE) && !rst;

   always_ff @(posedge clk) begin
      if (!rst && state == REFILL && bus.mem_req && bus.mem_ack) begin
         data_arr[idx][way_r] <= bus.mem_rdata;
         tag_arr[idx][way_r]  <= req_tag;
      end else if (!rst && state == RESPOND && write_r) begin
         data_arr[idx][way_r][wsel*WW +: WW] <= wdata_r;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         valid_arr      <= '0;
         dirty_arr      <= '0;
         age_arr        <= {NO_SETS{age_init}};
         hit_count      <= '0;
         miss_count     <= '0;
         addr_r         <= '0;
         wdata_r        <= '0;
         write_r        <= 1'b0;
         hit_r          <= 1'b0;
         way_r          <= '0;
         bus.resp_valid <= 1'b0;
         bus.resp_rdata <= '0;
         bus.resp_hit   <= 1'b0;
         bus.mem_req    <= 1'b0;
         bus.mem_write  <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_wdata  <= '0;
      end else begin
         bus.resp_valid <= 1'b0;
         case (state)
            IDLE: if (bus.req_valid) begin
               addr_r  <= bus.req_addr;
               wdata_r <= bus.req_wdata;
               write_r <= bus.req_write;
               state   <= LOOKUP;
            end
            LOOKUP: if (hit_any) begin
               hit_count <= hit_count + 32'd1;
               hit_r     <= 1'b1;
               way_r     <= hit_way;
               state     <= RESPOND;
            end else begin
               miss_count  <= miss_count + 32'd1;
               hit_r       <= 1'b0;
               way_r       <= victim;
               bus.mem_req <= 1'b1;
               if (valid_arr[idx][victim] && dirty_arr[idx][victim]) begin
                  bus.mem_write <= 1'b1;
                  bus.mem_addr  <= {tag_arr[idx][victim], idx, {OFFSET_BITS{1'b0}}};
                  bus.mem_wdata <= data_arr[idx][victim];
                  state         <= WRITEBACK;
               end else begin
                  bus.mem_write <= 1'b0;
                  bus.mem_addr  <= {req_tag, idx, {OFFSET_BITS{1'b0}}};
                  state         <= REFILL;
               end
            end
            WRITEBACK: if (bus.mem_ack) begin
               bus.mem_req <= 1'b0;
               state       <= REFILL;
            end
            // Entered with mem_req low after a writeback: issue the refill next.
            REFILL: if (!bus.mem_req) begin
               bus.mem_req   <= 1'b1;
               bus.mem_write <= 1'b0;
               bus.mem_addr  <= {req_tag, idx, {OFFSET_BITS{1'b0}}};
            end else if (bus.mem_ack) begin
               bus.mem_req           <= 1'b0;
               valid_arr[idx][way_r] <= 1'b1;
               dirty_arr[idx][way_r] <= 1'b0;
               state                 <= RESPOND;
            end
            RESPOND: begin
               bus.resp_valid <= 1'b1;
               bus.resp_hit   <= hit_r;
               bus.resp_rdata <= write_r ? wdata_r : cur_line[wsel*WW +: WW];
               if (write_r) dirty_arr[idx][way_r] <= 1'b1;
               for (int w = 0; w < CACHE_TYPE; w++) begin
                  if (AGE_BITS'(w) == way_r)
                     age_arr[idx][w] <= '0;
                  else if (age_arr[idx][w] < age_arr[idx][way_r])
                     age_arr[idx][w] <= age_arr[idx][w] + 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed bench for assoc_cache_ctrl: response and memory-transaction scoreboards
// checked by independent monitor / memory-responder processes.
module tb_assoc_cache_ctrl;
   logic        clk;
   logic        rst;
   logic [31:0] hit_count;
   logic [31:0] miss_count;
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   int          mem_lat = 0;
   logic        expect_abort = 1'b0;
   logic        mem_busy = 1'b0;

   assoc_cache_ctrl_if #(.WORD_SIZE(4), .BLOCK_SIZE(64)) mif ();

   assoc_cache_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (mif),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   typedef struct {
      logic [31:0] d;
      logic        h;
      int          acc;
      logic        lat;
   } resp_exp_t;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      int          wword;
      logic [31:0] wval;
   } mem_exp_t;

   resp_exp_t sb[$];
   mem_exp_t  mq[$];
   logic [511:0] mem_model [logic [31:0]];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: bound expired or unexpected event", name);
   endtask

   // Default memory content: each word holds its own byte address.
   function automatic logic [511:0] line_of(input logic [31:0] a);
      logic [511:0] l;
      if (mem_model.exists(a)) return mem_model[a];
      for (int i = 0; i < 16; i++) l[i*32 +: 32] = a + 32'(4*i);
      return l;
   endfunction

   // Response monitor
   always @(negedge clk) begin
      if (!rst && mif.resp_valid) begin
         if (sb.size() == 0) fail_now("unexpected_resp");
         else begin
            resp_exp_t e;
            e = sb.pop_front();
            chk("resp_rdata", 512'(mif.resp_rdata), 512'(e.d));
            chk("resp_hit", 512'(mif.resp_hit), 512'(e.h));
            if (e.lat) chk("hit_latency", 512'(cyc - e.acc), 512'(2));
         end
      end
   end

   // Memory responder
   initial begin
      logic         cap_w;
      logic [31:0]  cap_a;
      logic [511:0] cap_d;
      logic         aborted;
      mem_exp_t     m;
      mif.mem_ack   = 1'b0;
      mif.mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (mif.mem_req) begin
            mem_busy = 1'b1;
            aborted  = 1'b0;
            cap_w = mif.mem_write;
            cap_a = mif.mem_addr;
            cap_d = mif.mem_wdata;
            if (mq.size() == 0) fail_now("unexpected_mem_req");
            else begin
               m = mq.pop_front();
               chk("mem_write", 512'(cap_w), 512'(m.wr));
               chk("mem_addr", 512'(cap_a), 512'(m.addr));
               if (m.wword >= 0) chk("mem_wdata_word", 512'(cap_d[m.wword*32 +: 32]), 512'(m.wval));
            end
            for (int i = 0; i < mem_lat; i++) begin
               @(posedge clk); #1;
               if (!mif.mem_req) begin
                  if (!expect_abort && !aborted) fail_now("mem_req_dropped");
                  aborted = 1'b1;
               end else begin
                  chk("mem_addr_stable", 512'(mif.mem_addr), 512'(cap_a));
                  chk("mem_wdata_stable", mif.mem_wdata, cap_d);
                  chk("mem_write_stable", 512'(mif.mem_write), 512'(cap_w));
                  chk("req_ready_busy", 512'(mif.req_ready), 512'(0));
               end
            end
            mif.mem_rdata = line_of(cap_a);
            mif.mem_ack   = 1'b1;
            @(posedge clk); #1;
            mif.mem_ack = 1'b0;
            if (!aborted) begin
               chk("mem_req_low_after_ack", 512'(mif.mem_req), 512'(0));
               if (cap_w) mem_model[cap_a] = cap_d;
            end
            mem_busy = 1'b0;
         end
      end
   end

   task automatic wait_accept(output int acc);
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!mif.req_ready && n < 200);
      if (!mif.req_ready) fail_now("req_accept_timeout");
      @(posedge clk); #1;
      mif.req_valid = 1'b0;
      acc = cyc;
   endtask

   task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_h, input logic lat);
      int acc;
      int n;
      mif.req_valid = 1'b1;
      mif.req_write = wr;
      mif.req_addr  = a;
      mif.req_wdata = wd;
      wait_accept(acc);
      sb.push_back('{exp_d, exp_h, acc, lat});
      n = 0;
      while (sb.size() != 0 && n < 500) begin @(posedge clk); n++; end
      if (sb.size() != 0) begin
         fail_now("resp_timeout");
         sb.delete();
      end
      #1;
   endtask

   task automatic refill(input logic [31:0] a);
      mq.push_back('{1'b0, a, -1, 32'h0});
   endtask

   task automatic do_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("req_ready_in_rst", 512'(mif.req_ready), 512'(0));
      rst = 1'b0;
      #1;
      chk("rst_resp_valid", 512'(mif.resp_valid), 512'(0));
      chk("rst_resp_rdata", 512'(mif.resp_rdata), 512'(0));
      chk("rst_resp_hit", 512'(mif.resp_hit), 512'(0));
      chk("rst_mem_req", 512'(mif.mem_req), 512'(0));
      chk("rst_mem_write", 512'(mif.mem_write), 512'(0));
      chk("rst_mem_addr", 512'(mif.mem_addr), 512'(0));
      chk("rst_mem_wdata", mif.mem_wdata, 512'(0));
      chk("rst_hit_count", 512'(hit_count), 512'(0));
      chk("rst_miss_count", 512'(miss_count), 512'(0));
      chk("rst_req_ready", 512'(mif.req_ready), 512'(1));
   endtask

   initial begin
      logic [511:0] l;
      int acc;
      int n;
      mif.req_valid = 1'b0;
      mif.req_write = 1'b0;
      mif.req_addr  = '0;
      mif.req_wdata = '0;
      l = line_of(32'h40);
      l[31:0] = 32'hDEADBEEF;
      mem_model[32'h40] = l;
      @(posedge clk); #1;
      do_reset();

      // Cold miss then hit on the same line
      refill(32'h40);
      do_req(1'b0, 32'h40, '0, 32'hDEADBEEF, 1'b0, 1'b0);
      do_req(1'b0, 32'h40, '0, 32'hDEADBEEF, 1'b1, 1'b1);
      chk("t1_hit_count", 512'(hit_count), 512'(1));
      chk("t1_miss_count", 512'(miss_count), 512'(1));

      // Fill set 1, touch way 0, then evict clean way 1
      refill(32'h2040); do_req(1'b0, 32'h2040, '0, 32'h2040, 1'b0, 1'b0);
      refill(32'h4040); do_req(1'b0, 32'h4040, '0, 32'h4040, 1'b0, 1'b0);
      refill(32'h6040); do_req(1'b0, 32'h6040, '0, 32'h6040, 1'b0, 1'b0);
      do_req(1'b0, 32'h40, '0, 32'hDEADBEEF, 1'b1, 1'b1);
      refill(32'h8040); do_req(1'b0, 32'h8040, '0, 32'h8040, 1'b0, 1'b0);
      chk("t2_hit_count", 512'(hit_count), 512'(2));
      chk("t2_miss_count", 512'(miss_count), 512'(5));

      // Dirty eviction: writeback of 0x2040 then refill of 0x8040
      do_reset();
      refill(32'h40);   do_req(1'b0, 32'h40,   '0, 32'hDEADBEEF, 1'b0, 1'b0);
      refill(32'h2040); do_req(1'b0, 32'h2040, '0, 32'h2040, 1'b0, 1'b0);
      refill(32'h4040); do_req(1'b0, 32'h4040, '0, 32'h4040, 1'b0, 1'b0);
      refill(32'h6040); do_req(1'b0, 32'h6040, '0, 32'h6040, 1'b0, 1'b0);
      do_req(1'b1, 32'h2044, 32'h12345678, 32'h12345678, 1'b1, 1'b1);
      do_req(1'b0, 32'h4040, '0, 32'h4040, 1'b1, 1'b1);
      do_req(1'b0, 32'h6040, '0, 32'h6040, 1'b1, 1'b1);
      do_req(1'b0, 32'h40,   '0, 32'hDEADBEEF, 1'b1, 1'b1);
      mq.push_back('{1'b1, 32'h2040, 1, 32'h12345678});
      refill(32'h8040);
      do_req(1'b0, 32'h8040, '0, 32'h8040, 1'b0, 1'b0);
      chk("t3_hit_count", 512'(hit_count), 512'(4));
      chk("t3_miss_count", 512'(miss_count), 512'(5));

      // Write-allocate miss, then read back
      refill(32'hA040);
      do_req(1'b1, 32'hA048, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0);
      do_req(1'b0, 32'hA048, '0, 32'hCAFEF00D, 1'b1, 1'b1);

      // Slow memory with an ignored request pulse during the refill
      mem_lat = 10;
      refill(32'hC0);
      fork
         do_req(1'b0, 32'hC0, '0, 32'hC0, 1'b0, 1'b0);
         begin
            n = 0;
            while (!mif.mem_req && n < 50) begin @(posedge clk); n++; end
            repeat (3) @(posedge clk);
            #1;
            chk("bp_req_ready", 512'(mif.req_ready), 512'(0));
            mif.req_valid = 1'b1;
            mif.req_write = 1'b1;
            mif.req_addr  = 32'hC4;
            mif.req_wdata = 32'hBAD0BAD0;
            @(posedge clk); #1;
            mif.req_valid = 1'b0;
            mif.req_write = 1'b0;
         end
      join
      mem_lat = 0;
      do_req(1'b0, 32'hC4, '0, 32'hC4, 1'b1, 1'b1);

      // Reset in the middle of a refill; the late ack must be ignored
      mem_lat = 6;
      expect_abort = 1'b1;
      refill(32'h1C0);
      mif.req_valid = 1'b1;
      mif.req_write = 1'b0;
      mif.req_addr  = 32'h1C0;
      wait_accept(acc);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("abort_mem_req", 512'(mif.mem_req), 512'(0));
      chk("abort_req_ready", 512'(mif.req_ready), 512'(1));
      chk("abort_hit_count", 512'(hit_count), 512'(0));
      chk("abort_miss_count", 512'(miss_count), 512'(0));
      n = 0;
      while (mem_busy && n < 50) begin @(posedge clk); #1; n++; end
      if (mem_busy) fail_now("abort_mem_busy");
      repeat (3) @(posedge clk);
      #1;
      chk("late_ack_ready", 512'(mif.req_ready), 512'(1));
      chk("late_ack_mem_req", 512'(mif.mem_req), 512'(0));
      expect_abort = 1'b0;
      mem_lat = 0;
      refill(32'h40);
      do_req(1'b0, 32'h40, '0, 32'hDEADBEEF, 1'b0, 1'b0);
      chk("t6_hit_count", 512'(hit_count), 512'(0));
      chk("t6_miss_count", 512'(miss_count), 512'(1));
      if (mq.size() != 0) fail_now("mem_txn_missing");

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
